// File: rtl/dongwon_cache_ctrl_if.sv
// Bus bundle for the cache controller: CPU request side, cache array commands and RAM port.
// The controller uses the master view; CPU, cache array and RAM together use the slave view.
interface dongwon_cache_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ready;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  cache_run;
  logic                  cache_we;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_ack, cpu_rdata,
    output cache_run, cache_we, cache_addr, cache_wdata,
    input  cache_hit, cache_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_ack, cpu_rdata,
    input  cache_run, cache_we, cache_addr, cache_wdata,
    output cache_hit, cache_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dongwon_cache_ctrl.sv
// Direct-mapped cache controller: write-through, no-write-allocate, one request in flight.
// Define DONGWON_CACHE_CTRL_STATS_EN to add saturating hit_count/miss_count outputs.
module dongwon_cache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef DONGWON_CACHE_CTRL_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  dongwon_cache_ctrl_if.master  bus
`ifdef DONGWON_CACHE_CTRL_STATS_EN
  , output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
`endif
);

  localparam int OFFSET = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFFSET) - 64'd1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, COMPARE, MEM_RD, FILL, MEM_WR, DONE
  } state_t;

  state_t                state;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q;
  logic                  ack_q;
  logic                  run_q;
  logic                  fill_we_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic                  write_hit;

  // The hit result only arrives during COMPARE, so the write-hit update cannot be registered.
  assign write_hit = (state == COMPARE) && we_q && bus.cache_hit;

  assign bus.cpu_ready   = ready_q;
  assign bus.cpu_ack     = ack_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.cache_run   = run_q | write_hit;
  assign bus.cache_we    = fill_we_q | write_hit;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = (state == FILL) ? fill_q : wdata_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = addr_q & ~OFFSET_MASK;
  assign bus.mem_wdata   = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      fill_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      run_q     <= 1'b0;
      fill_we_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      run_q     <= 1'b0;
      fill_we_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      case (state)
        IDLE: begin
          if (bus.cpu_req && ready_q) begin
            we_q    <= bus.cpu_we;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            ready_q <= 1'b0;
            run_q   <= 1'b1;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          state <= COMPARE;
        end
        COMPARE: begin
          if (!we_q && bus.cache_hit) begin
            rdata_q <= bus.cache_rdata;
            ack_q   <= 1'b1;
            state   <= DONE;
          end else begin
            mem_req_q <= 1'b1;
            mem_we_q  <= we_q;
            state     <= we_q ? MEM_WR : MEM_RD;
          end
        end
        MEM_RD: begin
          if (bus.mem_ack) begin
            fill_q    <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            run_q     <= 1'b1;
            fill_we_q <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          rdata_q <= fill_q;
          ack_q   <= 1'b1;
          state   <= DONE;
        end
        MEM_WR: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            ack_q     <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DONGWON_CACHE_CTRL_STATS_EN
  // Every COMPARE cycle is either a hit or a miss; counters stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == COMPARE) begin
      if (bus.cache_hit) begin
        if (hit_count != '1) hit_count <= hit_count + STAT_WIDTH'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + STAT_WIDTH'(1);
      end
    end
  end
`endif

endmodule
